// File: rtl/player_mover_if.sv
// player_mover_if
// Bundles the button/blocking-flag inputs and the position/colour outputs
// exchanged between the button front-end, the player_mover block and the
// rectangle array.
//   btns         4   one-hot direction request (8=up, 4=down, 2=right, 1=left)
//   colorBtn     1   colour-advance button level
//   upEnable     1   high = up step blocked
//   downEnable   1   high = down step blocked
//   leftEnable   1   high = left step blocked
//   rightEnable  1   high = right step blocked
//   player_hPos  32  player left edge
//   player_vPos  32  player top edge
//   player_color 4   current player colour
//   step_o       1   pulse: a position step was taken
//   blocked_o    1   pulse: a due step was suppressed
// Modports: master drives the requests and reads the player state,
//           slave is the player_mover side.
interface player_mover_if;
    logic [3:0]  btns;
    logic        colorBtn;
    logic        upEnable;
    logic        downEnable;
    logic        leftEnable;
    logic        rightEnable;
    logic [31:0] player_hPos;
    logic [31:0] player_vPos;
    logic [3:0]  player_color;
    logic        step_o;
    logic        blocked_o;

    modport master (
        output btns, colorBtn, upEnable, downEnable, leftEnable, rightEnable,
        input  player_hPos, player_vPos, player_color, step_o, blocked_o
    );

    modport slave (
        input  btns, colorBtn, upEnable, downEnable, leftEnable, rightEnable,
        output player_hPos, player_vPos, player_color, step_o, blocked_o
    );
endinterface

// File: rtl/player_mover.sv
// player_mover
// Turns one-hot button requests into single position steps with
// hold-to-repeat, suppresses steps that the rectangle array flags as blocked,
// wraps the player at the screen edges and cycles the player colour on each
// rising edge of colorBtn.
// Ports:
//   btnClk  in  movement clock; all state changes on its rising edge
//   rst     in  synchronous active-high reset
//   bus     slave side of player_mover_if (buttons, block flags, player state)
module player_mover #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PLAYER_SIZE  = 12,
    parameter int H_START      = 314,
    parameter int V_START      = 234,
    parameter int START_COLOR  = 1,
    parameter int NUM_COLORS   = 4,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2
) (
    input  logic           btnClk,
    input  logic           rst,
    player_mover_if.slave  bus
);

    localparam logic [31:0] H_MAX      = 32'(SCREEN_W - PLAYER_SIZE);
    localparam logic [31:0] V_MAX      = 32'(SCREEN_H - PLAYER_SIZE);
    localparam logic [31:0] H_RESET    = 32'(H_START);
    localparam logic [31:0] V_RESET    = 32'(V_START);
    localparam logic [3:0]  COLOR_INIT = 4'(START_COLOR);
    localparam logic [3:0]  COLOR_LAST = 4'(NUM_COLORS - 1);
    localparam logic [31:0] DELAY_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RATE_LAST  = 32'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } dirState_t;

    dirState_t   state;
    logic [31:0] counter;
    logic [3:0]  dirQ;
    logic        prevColorBtn;
    logic [31:0] hPos;
    logic [31:0] vPos;
    logic [3:0]  color;
    logic        stepReg;
    logic        blockedReg;

    logic        validDir;
    logic        stepDue;
    logic        dirBlocked;
    dirState_t   nextState;
    logic [31:0] nextCounter;
    logic [3:0]  nextDir;
    logic [31:0] nextH;
    logic [31:0] nextV;
    logic [3:0]  nextColor;

    // Direction FSM next-state: decides whether a step is due this edge.
    always_comb begin
        validDir    = 1'b0;
        stepDue     = 1'b0;
        nextState   = state;
        nextCounter = counter;
        nextDir     = dirQ;

        case (bus.btns)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: validDir = 1'b1;
            default:                            validDir = 1'b0;
        endcase

        if (!validDir) begin
            nextState   = IDLE;
            nextCounter = 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    stepDue     = 1'b1;
                    nextState   = HOLD;
                    nextCounter = 32'd0;
                    nextDir     = bus.btns;
                end
                HOLD, REPEAT: begin
                    if (bus.btns != dirQ) begin
                        // A new direction steps at once and restarts the delay.
                        stepDue     = 1'b1;
                        nextState   = HOLD;
                        nextCounter = 32'd0;
                        nextDir     = bus.btns;
                    end else if ((state == HOLD) && (counter == DELAY_LAST)) begin
                        stepDue     = 1'b1;
                        nextState   = REPEAT;
                        nextCounter = 32'd0;
                    end else if ((state == REPEAT) && (counter == RATE_LAST)) begin
                        stepDue     = 1'b1;
                        nextCounter = 32'd0;
                    end else begin
                        nextCounter = counter + 32'd1;
                    end
                end
                default: begin
                    nextState   = IDLE;
                    nextCounter = 32'd0;
                end
            endcase
        end
    end

    // Block-flag selection and wrapped position update for a due step.
    always_comb begin
        dirBlocked = 1'b0;
        nextH      = hPos;
        nextV      = vPos;

        case (bus.btns)
            4'b1000: dirBlocked = bus.upEnable;
            4'b0100: dirBlocked = bus.downEnable;
            4'b0010: dirBlocked = bus.rightEnable;
            4'b0001: dirBlocked = bus.leftEnable;
            default: dirBlocked = 1'b0;
        endcase

        if (stepDue && !dirBlocked) begin
            case (bus.btns)
                4'b1000: nextV = (vPos == 32'd0)  ? V_MAX : vPos - 32'd1;
                4'b0100: nextV = (vPos >= V_MAX)  ? 32'd0 : vPos + 32'd1;
                4'b0010: nextH = (hPos >= H_MAX)  ? 32'd0 : hPos + 32'd1;
                4'b0001: nextH = (hPos == 32'd0)  ? H_MAX : hPos - 32'd1;
                default: begin
                    nextH = hPos;
                    nextV = vPos;
                end
            endcase
        end else begin
            nextH = hPos;
            nextV = vPos;
        end
    end

    // Colour advances only on a rising edge of the colorBtn level.
    always_comb begin
        nextColor = color;
        if (bus.colorBtn && !prevColorBtn) begin
            nextColor = (color >= COLOR_LAST) ? 4'd0 : color + 4'd1;
        end else begin
            nextColor = color;
        end
    end

    // State, position, colour and pulse registers.
    always_ff @(posedge btnClk) begin
        if (rst) begin
            state        <= IDLE;
            counter      <= 32'd0;
            dirQ         <= 4'd0;
            prevColorBtn <= 1'b0;
            hPos         <= H_RESET;
            vPos         <= V_RESET;
            color        <= COLOR_INIT;
            stepReg      <= 1'b0;
            blockedReg   <= 1'b0;
        end else begin
            state        <= nextState;
            counter      <= nextCounter;
            dirQ         <= nextDir;
            prevColorBtn <= bus.colorBtn;
            hPos         <= nextH;
            vPos         <= nextV;
            color        <= nextColor;
            stepReg      <= stepDue && !dirBlocked;
            blockedReg   <= stepDue && dirBlocked;
        end
    end

    assign bus.player_hPos  = hPos;
    assign bus.player_vPos  = vPos;
    assign bus.player_color = color;
    assign bus.step_o       = stepReg;
    assign bus.blocked_o    = blockedReg;

endmodule
